// File: rtl/tdm_slot_rx.sv
// -----------------------------------------------------------------------------
// tdm_slot_rx
//   Multi-channel TDM PCM slot receiver. The slow slot clock is oversampled in
//   the clk domain. Each falling edge of s_clk captures one slot word. A
//   two-state machine (HUNT/LOCKED) aligns to frame sync and numbers the slots.
//   Words from enabled channels are tagged {slot, word} and queued in a
//   first-word fall-through FIFO that has a valid/ready output.
//
// Ports
//   clk, reset        system clock, asynchronous active-low reset
//   s_clk/s_fs/s_data slot clock, frame sync, slot word (asynchronous to clk)
//   ch_en             per-slot capture enable (bit k enables slot k)
//   clr_status        synchronous clear of the sticky overflow flag
//   o_valid/o_ready   FIFO head handshake; o_ch/o_data hold the head entry
//   fifo_level        number of occupied FIFO entries (0..FIFO_DEPTH)
//   locked            frame alignment currently held
//   frame_err         one-cycle pulse on a misplaced or missing frame sync
//   overflow          sticky; a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module tdm_slot_rx #(
  parameter  int NUM_CH     = 8,
  parameter  int SAMPLE_W   = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_clk,
  input  logic                s_fs,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                clr_status,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [CH_W-1:0]     o_ch,
  output logic [SAMPLE_W-1:0] o_data,
  output logic [AW:0]         fifo_level,
  output logic                locked,
  output logic                frame_err,
  output logic                overflow
);

  localparam int                LVL_W     = AW + 1;
  localparam int                EW        = CH_W + SAMPLE_W;
  localparam logic [CH_W-1:0]   LAST_SLOT = CH_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_e;

  logic                sclk_s1_q, sclk_s2_q, sclk_hist_q;
  logic                fs_s1_q, fs_s2_q;
  logic [SAMPLE_W-1:0] data_s1_q, data_s2_q;
  logic                strobe_s;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     slot_q, slot_d, slot_inc_s;
  logic                accept_s, ferr_s, push_s;
  logic [EW-1:0]       entry_s;

  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic                full_s, pop_s, wr_en_s, drop_s;
  logic                overflow_q, overflow_d, frame_err_q;

  // Two-flop synchronisers for the slot inputs, plus an s_clk history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_hist_q <= 1'b0;
      fs_s1_q     <= 1'b0;
      fs_s2_q     <= 1'b0;
      data_s1_q   <= {SAMPLE_W{1'b0}};
      data_s2_q   <= {SAMPLE_W{1'b0}};
    end else begin
      sclk_s1_q   <= s_clk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_hist_q <= sclk_s2_q;
      fs_s1_q     <= s_fs;
      fs_s2_q     <= fs_s1_q;
      data_s1_q   <= s_data;
      data_s2_q   <= data_s1_q;
    end
  end

  // The falling edge of synchronised s_clk is the capture point. Words are launched on the rise.
  assign strobe_s   = ~sclk_s2_q & sclk_hist_q;
  assign slot_inc_s = (slot_q == LAST_SLOT) ? {CH_W{1'b0}} : slot_q + CH_W'(1);

  // Frame state and slot counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      slot_q  <= {CH_W{1'b0}};
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state logic. The state only moves on a capture strobe.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    accept_s = 1'b0;
    ferr_s   = 1'b0;
    if (strobe_s) begin
      case (state_q)
        ST_HUNT: begin
          if (fs_s2_q) begin
            state_d  = ST_LOCKED;
            slot_d   = {CH_W{1'b0}};
            accept_s = 1'b1;
          end else begin
            state_d  = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (fs_s2_q && (slot_inc_s != {CH_W{1'b0}})) begin
            // Sync arrived early: realign so that this word becomes slot 0.
            ferr_s   = 1'b1;
            slot_d   = {CH_W{1'b0}};
            accept_s = 1'b1;
          end else if (!fs_s2_q && (slot_inc_s == {CH_W{1'b0}})) begin
            // Sync missing where slot 0 was due: drop the alignment and the word.
            ferr_s   = 1'b1;
            state_d  = ST_HUNT;
            slot_d   = {CH_W{1'b0}};
          end else begin
            slot_d   = slot_inc_s;
            accept_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_HUNT;
          slot_d  = {CH_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode for the FSM: push request and the tagged entry.
  always_comb begin
    push_s  = 1'b0;
    entry_s = {slot_d, data_s2_q};
    if (accept_s) begin
      push_s = ch_en[slot_d];
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO control. A pop frees room for a simultaneous push when the FIFO is full.
  always_comb begin
    full_s     = (count_q == DEPTH_LVL);
    pop_s      = (count_q != {LVL_W{1'b0}}) && o_ready;
    wr_en_s    = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear leaves overflow set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_status) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO storage, pointers, level and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {LVL_W{1'b0}};
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= entry_s;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= ferr_s;
    end
  end

  assign o_valid          = (count_q != {LVL_W{1'b0}});
  assign {o_ch, o_data}   = mem_q[rd_ptr_q];
  assign fifo_level       = count_q;
  assign locked           = (state_q == ST_LOCKED);
  assign frame_err        = frame_err_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_tdm_slot_rx.sv
// Scoreboard bench for tdm_slot_rx. A slot-level reference model pushes the
// expected {channel, word} entries into a queue. A monitor pops that queue on
// every accepted FIFO head and compares the two.
module tb_tdm_slot_rx;
  localparam int NUM_CH = 8, SAMPLE_W = 8, FIFO_DEPTH = 4, CH_W = 3;

  logic       clk = 1'b0, reset = 1'b0, s_clk = 1'b0, s_fs = 1'b0;
  logic [7:0] s_data = 8'h00, ch_en = 8'h00;
  logic       clr_status = 1'b0, o_ready = 1'b0;
  logic       o_valid, locked, frame_err, overflow;
  logic [CH_W-1:0] o_ch;
  logic [7:0] o_data;
  logic [2:0] fifo_level;

  tdm_slot_rx #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .s_clk(s_clk), .s_fs(s_fs), .s_data(s_data),
    .ch_en(ch_en), .clr_status(clr_status), .o_valid(o_valid), .o_ready(o_ready),
    .o_ch(o_ch), .o_data(o_data), .fifo_level(fifo_level), .locked(locked),
    .frame_err(frame_err), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int exp_q[$];
  int m_locked = 0, m_slot = 0, m_err = 0, m_ovf = 0;
  int fe_cnt = 0;
  logic fe_prev = 1'b0;
  int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random, 3 single pulse
  logic pulse_req = 1'b0;
  int rdy_cnt = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the framing rules to one slot and records the expected entry.
  task automatic model_slot(bit fs, bit [7:0] en, bit [7:0] d, bit coinc_pop);
    bit acc = 1'b0;
    int nxt;
    if (m_locked == 0) begin
      if (fs) begin m_locked = 1; m_slot = 0; acc = 1'b1; end
    end else begin
      nxt = (m_slot + 1) % NUM_CH;
      if (fs && nxt != 0) begin m_err++; m_slot = 0; acc = 1'b1; end
      else if (!fs && nxt == 0) begin m_err++; m_locked = 0; end
      else begin m_slot = nxt; acc = 1'b1; end
    end
    if (acc && en[m_slot]) begin
      if (exp_q.size() < FIFO_DEPTH || coinc_pop) exp_q.push_back(m_slot * 256 + int'(d));
      else m_ovf = 1;
    end
  endtask

  // Consumer ready generator. Random mode still guarantees a pop slot every fourth cycle.
  initial forever begin
    @(posedge clk);
    #1;
    rdy_cnt++;
    case (rdy_mode)
      0: o_ready = 1'b0;
      1: o_ready = 1'b1;
      2: o_ready = (rdy_cnt % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      default: o_ready = pulse_req;
    endcase
  end

  // Monitor: compares each accepted head against the scoreboard and tracks frame_err pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_entry: got ch=%0d data=%02h, none expected at %0t", o_ch, o_data, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          checks++;
          if ({21'd0, o_ch, o_data} != e) begin
            failures++;
            $display("FAIL entry: got ch=%0d data=%02h expected ch=%0d data=%02h at %0t",
                     o_ch, o_data, e / 256, e % 256, $time);
          end
        end
      end
      if (frame_err) fe_cnt++;
      if (frame_err && fe_prev) begin
        checks++; failures++;
        $display("FAIL frame_err_width: got 2-cycle pulse expected 1 at %0t", $time);
      end
      fe_prev = frame_err;
    end else begin
      fe_prev = 1'b0;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one slot: launch on the s_clk rise, capture at the fall. Each phase lasts 3..5 clk periods.
  task automatic send_slot(bit fs, bit [7:0] d, bit [7:0] en, bit meas, bit coinc);
    int h, lat;
    h = $urandom_range(3, 5);
    lat = 0;
    model_slot(fs, en, d, coinc);
    @(posedge clk); #2;
    s_fs = fs; s_data = d; ch_en = en; s_clk = 1'b1;
    repeat (h) @(posedge clk);
    #2;
    s_clk = 1'b0;
    for (int i = 1; i <= h; i++) begin
      @(posedge clk);
      pulse_req = coinc && (i == 2);
      #1;
      if (meas && lat == 0 && o_valid) lat = i;
    end
    pulse_req = 1'b0;
    if (meas) check("first_valid_latency", lat, 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0;
    bit [7:0] en_r;
    int fs_pos;
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk); #2 reset = 1'b1;

    // Basic lock: three frames, every channel enabled
    rdy_mode = 1;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 8; s++) begin
        send_slot(s == 0, 8'h10 + 8'(s), 8'hFF, (f == 0 && s == 0), 1'b0);
        if (f == 0 && s == 0) check("locked_after_fs", locked, 1);
      end
    idle(12);
    check("basic_frame_err", fe_cnt, 0);
    check("basic_all_out", exp_q.size(), 0);

    // Channel mask: only channel 0 captured
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 8; s++)
        send_slot(s == 0, (s == 0) ? 8'hA5 : 8'h00, 8'h01, 1'b0, 1'b0);
    idle(12);
    check("mask_all_out", exp_q.size(), 0);

    // Misplaced sync at slot 5 of frame 2
    fe0 = fe_cnt;
    for (int s = 0; s < 8; s++) send_slot(s == 0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    for (int s = 0; s < 6; s++) send_slot(s == 0 || s == 5, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    for (int s = 1; s < 8; s++) send_slot(1'b0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    send_slot(1'b1, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    idle(12);
    check("misplaced_fe", fe_cnt - fe0, 1);
    check("misplaced_locked", locked, 1);
    check("misplaced_out", exp_q.size(), 0);

    // Missing sync at the next frame boundary
    fe0 = fe_cnt;
    for (int s = 1; s < 8; s++) send_slot(1'b0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    send_slot(1'b0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    idle(6);
    check("missing_locked", locked, 0);
    check("missing_fe", fe_cnt - fe0, 1);
    for (int s = 0; s < 3; s++) send_slot(1'b0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    idle(6);
    check("hunt_no_entries", fifo_level, 0);
    for (int s = 0; s < 8; s++) send_slot(s == 0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    idle(12);
    check("resume_locked", locked, 1);
    check("resume_out", exp_q.size(), 0);
    check("resume_fe", fe_cnt, m_err);

    // Backpressure: 6 enabled slots into a 4-deep FIFO
    rdy_mode = 0;
    for (int s = 0; s < 8; s++) send_slot(s == 0, 8'($urandom), 8'h3F, 1'b0, 1'b0);
    idle(6);
    check("bp_level", fifo_level, 4);
    check("bp_overflow", overflow, m_ovf);
    @(posedge clk); #2 clr_status = 1'b1;
    @(posedge clk); #2 clr_status = 1'b0;
    m_ovf = 0;
    #1;
    check("clr_overflow", overflow, 0);
    rdy_mode = 3;
    send_slot(1'b1, 8'h5A, 8'h01, 1'b0, 1'b1);
    idle(6);
    check("coinc_level", fifo_level, 4);
    check("coinc_overflow", overflow, 0);
    rdy_mode = 1;
    idle(20);
    check("bp_drain_level", fifo_level, 0);
    check("bp_drain_out", exp_q.size(), 0);

    // Reset mid-frame with two entries queued
    rdy_mode = 0;
    for (int s = 1; s < 8; s++) send_slot(1'b0, 8'($urandom), 8'h00, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) send_slot(s == 0, 8'($urandom), 8'h05, 1'b0, 1'b0);
    check("pre_reset_level", fifo_level, 2);
    #1 reset = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_locked", locked, 0);
    exp_q.delete();
    m_locked = 0; m_slot = 0;
    idle(3);
    @(posedge clk); #2 reset = 1'b1;
    rdy_mode = 1;
    send_slot(1'b0, 8'h77, 8'hFF, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) send_slot(s == 0, 8'($urandom), 8'hFF, 1'b0, 1'b0);
    idle(12);
    check("post_rst_locked", locked, 1);
    check("post_rst_out", exp_q.size(), 0);

    // Random frames with occasional sync faults and random consumer stalls
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      en_r = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       fs_pos = -1;
        1:       fs_pos = $urandom_range(1, 7);
        default: fs_pos = 0;
      endcase
      for (int s = 0; s < 8; s++) send_slot(s == fs_pos, 8'($urandom), en_r, 1'b0, 1'b0);
    end
    idle(20);
    check("rand_out", exp_q.size(), 0);
    check("rand_fe", fe_cnt, m_err);
    check("rand_overflow", overflow, m_ovf);
    check("rand_locked", locked, m_locked);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
